// File: rtl/demux_1_to_n_request_engine_if.sv
// Bundle of the request demux handshake signals: upstream pull side, per-port
// FWFT drain side and status. The slave modport is the demux, the master its environment.
interface demux_1_to_n_request_engine_if #(
  parameter int NUM_ENGINE_RECEIVER = 4,
  parameter int ID_WIDTH            = 4,
  parameter int PAYLOAD_WIDTH       = 64
);
  logic                                         request_in_valid;
  logic [ID_WIDTH-1:0]                          request_in_id;
  logic [PAYLOAD_WIDTH-1:0]                     request_in_payload;
  logic                                         fifo_request_rd_en_out;
  logic [NUM_ENGINE_RECEIVER-1:0]               request_out_valid;
  logic [NUM_ENGINE_RECEIVER*PAYLOAD_WIDTH-1:0] request_out_payload;
  logic [NUM_ENGINE_RECEIVER-1:0]               request_out_ready;
  logic [NUM_ENGINE_RECEIVER-1:0]               port_prog_full;
  logic [15:0]                                  drop_count;
  logic                                         fifo_setup_signal;

  modport master (
    output request_in_valid, request_in_id, request_in_payload, request_out_ready,
    input  fifo_request_rd_en_out, request_out_valid, request_out_payload,
           port_prog_full, drop_count, fifo_setup_signal
  );

  modport slave (
    input  request_in_valid, request_in_id, request_in_payload, request_out_ready,
    output fifo_request_rd_en_out, request_out_valid, request_out_payload,
           port_prog_full, drop_count, fifo_setup_signal
  );
endinterface

// File: rtl/demux_1_to_n_request_engine.sv
// Steers packets pulled from the arbiter FIFO into per-destination FWFT buffers,
// throttling the upstream pull on prog-full and counting dropped packets.
module demux_1_to_n_request_engine #(
  parameter int NUM_ENGINE_RECEIVER = 4,
  parameter int ID_WIDTH            = 4,
  parameter int PAYLOAD_WIDTH       = 64,
  parameter int FIFO_DEPTH          = 16,
  parameter int PROG_THRESH         = FIFO_DEPTH - 6,
  parameter int INIT_CYCLES         = 4
) (
  input logic                          ap_clk,
  input logic                          areset,
  demux_1_to_n_request_engine_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

  logic [INIT_W-1:0]        init_cnt;
  logic                     setup_q;
  logic                     in_valid_q;
  logic [ID_WIDTH-1:0]      in_id_q;
  logic [PAYLOAD_WIDTH-1:0] in_payload_q;

  logic [PAYLOAD_WIDTH-1:0] mem [NUM_ENGINE_RECEIVER][FIFO_DEPTH];
  logic [CNT_W-1:0]         count  [NUM_ENGINE_RECEIVER];
  logic [PTR_W-1:0]         wr_ptr [NUM_ENGINE_RECEIVER];
  logic [PTR_W-1:0]         rd_ptr [NUM_ENGINE_RECEIVER];

  logic [NUM_ENGINE_RECEIVER-1:0]               pop;
  logic [NUM_ENGINE_RECEIVER-1:0]               wr_hit;
  logic [NUM_ENGINE_RECEIVER-1:0]               prog_full_q;
  logic [NUM_ENGINE_RECEIVER-1:0]               out_valid;
  logic [NUM_ENGINE_RECEIVER*PAYLOAD_WIDTH-1:0] out_payload;
  logic                                         drop;
  logic                                         rd_en_q;
  logic [15:0]                                  drop_count_q;

  // Init window: setup stays high until INIT_CYCLES clean cycles have elapsed.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      init_cnt <= '0;
      setup_q  <= 1'b1;
    end else if (setup_q) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == INIT_W'(INIT_CYCLES - 1)) setup_q <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) in_valid_q <= 1'b0;
    else        in_valid_q <= bus.request_in_valid && !setup_q;
  end

  always_ff @(posedge ap_clk) begin
    in_id_q      <= bus.request_in_id;
    in_payload_q <= bus.request_in_payload;
  end

  // A full port still accepts a write when it is popping in the same cycle;
  // anything that matches no accepting port (bad id or full) is a drop.
  always_comb begin
    pop         = '0;
    wr_hit      = '0;
    out_valid   = '0;
    out_payload = '0;
    for (int i = 0; i < NUM_ENGINE_RECEIVER; i++) begin
      out_valid[i] = (count[i] != '0);
      pop[i]       = out_valid[i] && bus.request_out_ready[i];
      wr_hit[i]    = in_valid_q && (in_id_q == ID_WIDTH'(i)) &&
                     ((count[i] != CNT_W'(FIFO_DEPTH)) || pop[i]);
      if (out_valid[i])
        out_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem[i][rd_ptr[i]];
    end
    drop = in_valid_q && (wr_hit == '0);
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      for (int i = 0; i < NUM_ENGINE_RECEIVER; i++) begin
        count[i]       <= '0;
        wr_ptr[i]      <= '0;
        rd_ptr[i]      <= '0;
        prog_full_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ENGINE_RECEIVER; i++) begin
        if (wr_hit[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (wr_hit[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !wr_hit[i]) count[i] <= count[i] - 1'b1;
        prog_full_q[i] <= (count[i] >= CNT_W'(PROG_THRESH));
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < NUM_ENGINE_RECEIVER; i++)
      if (wr_hit[i]) mem[i][wr_ptr[i]] <= in_payload_q;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rd_en_q      <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rd_en_q <= !setup_q && (prog_full_q == '0);
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign bus.fifo_request_rd_en_out = rd_en_q;
  assign bus.request_out_valid      = out_valid;
  assign bus.request_out_payload    = out_payload;
  assign bus.port_prog_full         = prog_full_q;
  assign bus.drop_count             = drop_count_q;
  assign bus.fifo_setup_signal      = setup_q;
endmodule

// File: doc/demux_1_to_n_request_engine.md
Name: demux_1_to_N_request_engine

Overview:
- Downstream stage of the N-to-1 request arbiter. Pulls EnginePackets out of the arbiter's output FIFO using the rd_en pull handshake.
- Decodes a destination id carried with each packet and steers the packet into one of NUM_ENGINE_RECEIVER per-port FWFT buffers. Each buffer drains through its own valid/ready handshake.
- Throttles the upstream pull with a prog-full threshold, so the upstream read latency never overflows a port buffer.
- Counts dropped packets.

Parameters:
- NUM_ENGINE_RECEIVER, 4: number of output ports, range 2..16.
- ID_WIDTH, 4: width of the destination id field; must satisfy 2**ID_WIDTH >= NUM_ENGINE_RECEIVER.
- PAYLOAD_WIDTH, 64: packet payload width in bits.
- FIFO_DEPTH, 16: entries per port buffer; must be a power of 2 and >= 8.
- PROG_THRESH, FIFO_DEPTH-6: occupancy at or above which a port reports prog_full. Headroom of 6 covers the upstream pull latency.
- INIT_CYCLES, 4: cycles after reset release during which fifo_setup_signal stays high.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  reset; one clock, reset is synchronous and active-high.
- request_in_valid  in  1  upstream packet valid.
- request_in_id  in  ID_WIDTH  destination port of the packet.
- request_in_payload  in  PAYLOAD_WIDTH  packet payload.
- fifo_request_rd_en_out  out  1  pull request to the upstream FIFO (its rd_en).
- request_out_valid  out  NUM_ENGINE_RECEIVER  per-port head valid.
- request_out_payload  out  NUM_ENGINE_RECEIVER*PAYLOAD_WIDTH  per-port head payload; port i occupies bits [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
- request_out_ready  in  NUM_ENGINE_RECEIVER  per-port consumer ready.
- port_prog_full  out  NUM_ENGINE_RECEIVER  per-port occupancy >= PROG_THRESH (registered).
- drop_count  out  16  count of dropped packets, saturating.
- fifo_setup_signal  out  1  block is initialising.

Behaviour:
- Reset values while areset=1:
  - all outputs 0, except fifo_setup_signal=1;
  - all occupancy counts, read/write pointers and drop_count = 0;
  - the registered input valid is cleared.
  - Payload registers are not reset.
- Init counter: counts INIT_CYCLES cycles after areset falls. fifo_setup_signal deasserts on the cycle the count completes, i.e. it goes low exactly INIT_CYCLES cycles after areset deasserts.
- Input stage: request_in_* is registered every cycle; the valid bit is reset-gated. Inputs are ignored while fifo_setup_signal=1.
- Write stage: one cycle after capture, the packet is written into port[id].
  - Drop when id >= NUM_ENGINE_RECEIVER.
  - Drop when port[id] count == FIFO_DEPTH and port[id] is not popping in that same cycle.
  - A write and a pop on a full port in the same cycle are both accepted; the count is unchanged.
  - Each drop increments drop_count by 1, saturating at 16'hFFFF.
- Output (FWFT):
  - request_out_valid[i] = (count[i] != 0).
  - request_out_payload[i] = the entry at the read pointer.
  - Pop occurs when request_out_valid[i] & request_out_ready[i]; the read pointer advances with modulo-FIFO_DEPTH wrap.
  - Latency: request_in_valid sampled at edge E0 → request_out_valid high after edge E1 (2 cycles), when the port was empty.
- Count update per port:
  - write only: +1;
  - pop only: -1;
  - write and pop together: unchanged.
  - The count never exceeds FIFO_DEPTH and never underflows.
- port_prog_full[i] is registered: (count[i] >= PROG_THRESH).
- fifo_request_rd_en_out is registered; it is 1 iff fifo_setup_signal=0, areset=0 and port_prog_full == 0.
  - The upstream FIFO may return no data for a pull (upstream empty). This is legal; no credit tracking is performed.
- Ordering: packets to the same port leave in arrival order. There is no ordering guarantee across ports.
- Reset mid-operation: all buffered packets are discarded. Outputs return to their reset values on the next edge, and the init sequence repeats.

Test Plan:
- Reset release: hold areset 3 cycles, then release → fifo_setup_signal=1 for exactly 4 cycles then 0; fifo_request_rd_en_out rises the next cycle; all request_out_valid=0; drop_count=0.
- Single packet: valid, id=2, payload=64'hA5 at cycle T → request_out_valid=4'b0100 at T+2 with payload 64'hA5; with ready[2]=1 the valid drops at T+3.
- Fill and throttle: stream 16 packets to id=1 with ready[1]=0 → port_prog_full[1] rises when count reaches 10; rd_en_out falls the following cycle; packets 11-16 are buffered; drop_count=0; count=16.
- Overflow and bad id: with port 1 full, send id=1 → drop_count=1; send id=7 → drop_count=2; the contents of port 1 are unchanged.
- Simultaneous write and pop on a full port: port 0 full, ready[0]=1 and an incoming id=0 packet in the same cycle → no drop, count stays 16, FIFO order preserved (verified through 32 wrap-around transfers).
- Mid-stream reset: assert areset with 5 packets buffered across ports → next cycle all request_out_valid=0, drop_count=0, fifo_setup_signal=1; post-reset traffic passes correctly.
